// File: rtl/fp_issue_sequencer.sv
// In-order issue sequencer for the iterative FP core: holds one instruction,
// stalls on RAW hazards against a fixed-latency scoreboard, and drives write-back.
module fp_issue_sequencer #(
  parameter int unsigned DSP_LAT = 4,
  parameter int unsigned AW      = 5,
  parameter int unsigned OPW     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_op,
  input  logic [AW-1:0]  instr_rd,
  input  logic [AW-1:0]  instr_ra,
  input  logic [AW-1:0]  instr_rb,
  input  logic [AW-1:0]  instr_rc,
  input  logic [2:0]     instr_src,
  input  logic           flush,
  output logic [AW-1:0]  addr_a,
  output logic [AW-1:0]  addr_b,
  output logic [AW-1:0]  addr_c,
  output logic [OPW-1:0] dsp_op,
  output logic           dsp_go,
  output logic [AW-1:0]  addr_w,
  output logic           we,
  output logic           busy
);

  logic                          held_q, held_d;
  logic [OPW-1:0]                op_q, op_d;
  logic [AW-1:0]                 rd_q, rd_d;
  logic [AW-1:0]                 ra_q, ra_d;
  logic [AW-1:0]                 rb_q, rb_d;
  logic [AW-1:0]                 rc_q, rc_d;
  logic [2:0]                    src_q, src_d;
  logic [DSP_LAT-1:0]            v_q, v_d;
  logic [DSP_LAT-1:0][AW-1:0]    sb_rd_q, sb_rd_d;
  logic                          hazard;
  logic                          accept;

  // RAW check includes the write-back stage: the regfile read returns the old value that cycle.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < DSP_LAT; k++) begin
      if (v_q[k] && ((src_q[0] && (sb_rd_q[k] == ra_q)) ||
                     (src_q[1] && (sb_rd_q[k] == rb_q)) ||
                     (src_q[2] && (sb_rd_q[k] == rc_q)))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & held_q;
  end

  assign dsp_go      = held_q & ~hazard & ~flush;
  assign instr_ready = ~flush & (~held_q | dsp_go);
  assign accept      = instr_valid & instr_ready;

  assign addr_a = ra_q;
  assign addr_b = rb_q;
  assign addr_c = rc_q;
  assign dsp_op = op_q;
  assign we     = v_q[DSP_LAT-1];
  assign addr_w = sb_rd_q[DSP_LAT-1];
  assign busy   = held_q | (|v_q);

  always_comb begin
    held_d  = held_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    src_d   = src_q;
    v_d     = v_q;
    sb_rd_d = sb_rd_q;

    if (accept) begin
      held_d = 1'b1;
      op_d   = instr_op;
      rd_d   = instr_rd;
      ra_d   = instr_ra;
      rb_d   = instr_rb;
      rc_d   = instr_rc;
      src_d  = instr_src;
    end else if (dsp_go || flush) begin
      held_d = 1'b0;
    end

    // Scoreboard shifts every cycle; stage 1 records whether this cycle issued.
    v_d[0]     = dsp_go;
    sb_rd_d[0] = rd_q;
    for (int unsigned k = 1; k < DSP_LAT; k++) begin
      v_d[k]     = v_q[k-1];
      sb_rd_d[k] = sb_rd_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q  <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      src_q   <= '0;
      v_q     <= '0;
      sb_rd_q <= '0;
    end else begin
      held_q  <= held_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      src_q   <= src_d;
      v_q     <= v_d;
      sb_rd_q <= sb_rd_d;
    end
  end

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Bench for fp_issue_sequencer: two builds (latency 4 and 1) share one stimulus
// stream and are checked every cycle against an issue-time based reference model.
module tb_fp_issue_sequencer;

  localparam int unsigned AW  = 5;
  localparam int unsigned OPW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           instr_valid = 1'b0;
  logic           flush = 1'b0;
  logic [OPW-1:0] instr_op = '0;
  logic [AW-1:0]  instr_rd = '0;
  logic [AW-1:0]  instr_ra = '0;
  logic [AW-1:0]  instr_rb = '0;
  logic [AW-1:0]  instr_rc = '0;
  logic [2:0]     instr_src = '0;

  logic           instr_ready [2];
  logic           dsp_go [2];
  logic           we [2];
  logic           busy [2];
  logic [AW-1:0]  addr_a [2];
  logic [AW-1:0]  addr_b [2];
  logic [AW-1:0]  addr_c [2];
  logic [AW-1:0]  addr_w [2];
  logic [OPW-1:0] dsp_op [2];

  always #5 clk = ~clk;

  fp_issue_sequencer #(.DSP_LAT(4), .AW(AW), .OPW(OPW)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready[0]),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_rc(instr_rc), .instr_src(instr_src), .flush(flush),
    .addr_a(addr_a[0]), .addr_b(addr_b[0]), .addr_c(addr_c[0]), .dsp_op(dsp_op[0]),
    .dsp_go(dsp_go[0]), .addr_w(addr_w[0]), .we(we[0]), .busy(busy[0])
  );

  fp_issue_sequencer #(.DSP_LAT(1), .AW(AW), .OPW(OPW)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready[1]),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_rc(instr_rc), .instr_src(instr_src), .flush(flush),
    .addr_a(addr_a[1]), .addr_b(addr_b[1]), .addr_c(addr_c[1]), .dsp_op(dsp_op[1]),
    .dsp_go(dsp_go[1]), .addr_w(addr_w[1]), .we(we[1]), .busy(busy[1])
  );

  // Reference model: remembers the cycle each register was last issued as a destination,
  // plus a short history of which cycles issued and to which register.
  bit             m_held [2];
  logic [OPW-1:0] m_op [2];
  logic [AW-1:0]  m_rd [2];
  logic [AW-1:0]  m_ra [2];
  logic [AW-1:0]  m_rb [2];
  logic [AW-1:0]  m_rc [2];
  logic [2:0]     m_src [2];
  int             last_iss [2][32];
  bit             iss_v [2][16];
  logic [AW-1:0]  iss_rd [2][16];

  int cyc = 64;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  function automatic int lat(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic model_reset(int i);
    m_held[i] = 1'b0;
    m_op[i] = '0; m_rd[i] = '0; m_ra[i] = '0; m_rb[i] = '0; m_rc[i] = '0; m_src[i] = '0;
    for (int r = 0; r < 32; r++) last_iss[i][r] = -100;
    for (int j = 0; j < 16; j++) begin iss_v[i][j] = 1'b0; iss_rd[i][j] = '0; end
  endtask

  // A result is still pending if its register was issued within the last L cycles.
  function automatic bit pending(int i, logic [AW-1:0] r);
    return (cyc - last_iss[i][r]) <= lat(i);
  endfunction

  function automatic bit m_go(int i);
    bit h;
    h = (m_src[i][0] && pending(i, m_ra[i])) ||
        (m_src[i][1] && pending(i, m_rb[i])) ||
        (m_src[i][2] && pending(i, m_rc[i]));
    return m_held[i] && !h && !flush;
  endfunction

  function automatic bit m_we(int i);
    return iss_v[i][(cyc - lat(i)) % 16];
  endfunction

  function automatic bit m_busy(int i);
    bit b;
    b = m_held[i];
    for (int j = 1; j <= lat(i); j++) b = b | iss_v[i][(cyc - j) % 16];
    return b;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s lat=%0d cyc=%0d observed=%0h expected=%0h", tag, lat(i), cyc, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit g [2];
    bit rdy [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      g[i]   = m_go(i);
      rdy[i] = !flush && (!m_held[i] || g[i]);
      chk("dsp_go", i, 32'(dsp_go[i]), 32'(g[i]));
      chk("instr_ready", i, 32'(instr_ready[i]), 32'(rdy[i]));
      chk("we", i, 32'(we[i]), 32'(m_we(i)));
      chk("busy", i, 32'(busy[i]), 32'(m_busy(i)));
      if (m_we(i)) chk("addr_w", i, 32'(addr_w[i]), 32'(iss_rd[i][(cyc - lat(i)) % 16]));
      if (m_held[i]) begin
        chk("addr_a", i, 32'(addr_a[i]), 32'(m_ra[i]));
        chk("addr_b", i, 32'(addr_b[i]), 32'(m_rb[i]));
        chk("addr_c", i, 32'(addr_c[i]), 32'(m_rc[i]));
        chk("dsp_op", i, 32'(dsp_op[i]), 32'(m_op[i]));
      end
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        iss_v[i][cyc % 16] = g[i];
        if (g[i]) begin
          iss_rd[i][cyc % 16] = m_rd[i];
          last_iss[i][m_rd[i]] = cyc;
        end
        if (instr_valid && rdy[i]) begin
          m_held[i] = 1'b1;
          m_op[i] = instr_op; m_rd[i] = instr_rd; m_ra[i] = instr_ra;
          m_rb[i] = instr_rb; m_rc[i] = instr_rc; m_src[i] = instr_src;
        end else if (g[i] || flush) begin
          m_held[i] = 1'b0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] rd, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rc, input logic [2:0] src, input logic [OPW-1:0] op);
    instr_valid = 1'b1; flush = 1'b0;
    instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_rc = rc; instr_src = src; instr_op = op;
    step();
  endtask

  task automatic idle(int n);
    instr_valid = 1'b0; flush = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset state
    rst_n = 1'b0; idle(2);
    rst_n = 1'b1; idle(2);

    // Independent back-to-back stream
    offer(5'd1, 5'd10, 5'd11, 5'd12, 3'b111, 4'd1);
    offer(5'd2, 5'd13, 5'd14, 5'd15, 3'b111, 4'd2);
    offer(5'd3, 5'd16, 5'd17, 5'd18, 3'b111, 4'd3);
    idle(8);

    // RAW on source A stalls the consumer
    offer(5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 4'd4);
    offer(5'd6, 5'd5, 5'd9, 5'd9, 3'b001, 4'd5);
    idle(10);

    // Matching register on an unused source does not stall
    offer(5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 4'd6);
    offer(5'd6, 5'd9, 5'd5, 5'd9, 3'b001, 4'd7);
    idle(8);

    // Flush of a stalled consumer; producer write-back still completes
    offer(5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 4'd8);
    offer(5'd6, 5'd5, 5'd9, 5'd9, 3'b001, 4'd9);
    idle(1);
    flush = 1'b1; step();
    idle(8);

    // Reset with results in flight
    offer(5'd7, 5'd1, 5'd2, 5'd3, 3'b111, 4'd10);
    offer(5'd8, 5'd1, 5'd2, 5'd3, 3'b111, 4'd11);
    idle(1);
    rst_n = 1'b0; step();
    rst_n = 1'b1; idle(8);

    // Flush and valid in the same cycle
    instr_valid = 1'b1; flush = 1'b1; instr_rd = 5'd9; instr_src = 3'b000; step();
    idle(3);

    // Randomized traffic over a small register set to provoke hazards
    repeat (800) begin
      instr_valid = ($urandom % 10) < 7;
      flush       = ($urandom % 20) == 0;
      instr_rd    = AW'($urandom % 8);
      instr_ra    = AW'($urandom % 8);
      instr_rb    = AW'($urandom % 8);
      instr_rc    = AW'($urandom % 8);
      instr_src   = 3'($urandom);
      instr_op    = OPW'($urandom);
      if (($urandom % 150) == 0) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end else begin
        step();
      end
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
